// File: rtl/branch_sequencer.sv
// Hard-wired control-step FSM: fetch (T0-T2) then conditional-branch execute (T3-T6).
// Optional single-step gating via `define BRANCH_SEQ_STEP_EN (adds the step port).
module branch_sequencer #(
   parameter int unsigned     MEM_WAIT = 0,
   parameter int unsigned     OP_W     = 5,
   parameter logic [OP_W-1:0] BR_OP    = OP_W'(5'b10010),
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   input  logic             halt,
`ifdef BRANCH_SEQ_STEP_EN
   input  logic             step,
`endif
   input  logic [OP_W-1:0] ir_op,
   input  logic             con_ff,
   output logic             PCout,
   output logic             MARIn,
   output logic             IncPC,
   output logic             ZIn,
   output logic             Zlowout,
   output logic             PCIn,
   output logic             read,
   output logic             MDRIn,
   output logic             MDRout,
   output logic             IRIn,
   output logic             Gra,
   output logic             Rout,
   output logic             CONIn,
   output logic             YIn,
   output logic             Cout,
   output logic             add,
   output logic [3:0]       present_state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      IDLE = 4'b0000,
      T0   = 4'b0111,
      T1   = 4'b1000,
      T2   = 4'b1001,
      T3   = 4'b1010,
      T4   = 4'b1011,
      T5   = 4'b1100,
      T6   = 4'b1101
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

   state_t           state_q, state_d;
   logic [3:0]       wait_q, wait_d;
   logic             cond_q, cond_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             adv;
   logic             is_br;
   logic             first;

`ifdef BRANCH_SEQ_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   assign is_br = (ir_op == BR_OP);
   // The wait counter only moves after the first cycle of a held step
   assign first = (wait_q == WAIT_INIT);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         wait_q  <= 4'd0;
         cond_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cond_q  <= cond_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      cond_d  = cond_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: if (run) state_d = T0;
         T0: begin
            if (adv) begin
               state_d = T1;
               wait_d  = WAIT_INIT;
            end
         end
         T1: begin
            if (adv) begin
               if (wait_q == 4'd0) state_d = T2;
               else                wait_d  = wait_q - 4'd1;
            end
         end
         T2: if (adv) state_d = T3;
         T3: if (adv) state_d = is_br ? T4 : IDLE;
         T4: if (adv) state_d = T5;
         T5: begin
            // Branch condition is captured as T6 begins and held for the step
            if (adv) begin
               state_d = T6;
               wait_d  = WAIT_INIT;
               cond_d  = con_ff;
            end
         end
         T6: begin
            if (adv) begin
               if (wait_q == 4'd0) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = halt ? IDLE : T0;
               end else begin
                  wait_d = wait_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      PCout   = 1'b0;
      MARIn   = 1'b0;
      IncPC   = 1'b0;
      ZIn     = 1'b0;
      Zlowout = 1'b0;
      PCIn    = 1'b0;
      read    = 1'b0;
      MDRIn   = 1'b0;
      MDRout  = 1'b0;
      IRIn    = 1'b0;
      Gra     = 1'b0;
      Rout    = 1'b0;
      CONIn   = 1'b0;
      YIn     = 1'b0;
      Cout    = 1'b0;
      add     = 1'b0;
      illegal = 1'b0;
      unique case (state_q)
         T0: begin
            PCout = 1'b1;
            MARIn = 1'b1;
            IncPC = 1'b1;
            ZIn   = 1'b1;
         end
         T1: begin
            read    = 1'b1;
            MDRIn   = 1'b1;
            Zlowout = first;
            PCIn    = first;
         end
         T2: begin
            MDRout = 1'b1;
            IRIn   = 1'b1;
         end
         T3: begin
            if (is_br) begin
               Gra   = 1'b1;
               Rout  = 1'b1;
               CONIn = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         T4: begin
            PCout = 1'b1;
            YIn   = 1'b1;
         end
         T5: begin
            Cout = 1'b1;
            add  = 1'b1;
            ZIn  = 1'b1;
         end
         T6: begin
            Zlowout = cond_q;
            PCIn    = cond_q;
         end
         default: ;
      endcase
   end

   assign present_state = state_q;
   assign instr_count   = cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: vector tables through a scoreboard plus reset/wrap sequences.
module tb_branch_sequencer;

   localparam logic [4:0] BR  = 5'b10010;
   localparam logic [4:0] BAD = 5'b00011;

   typedef struct {
      logic        sel;
      logic        run;
      logic        halt;
      logic        con;
      logic [4:0]  op;
      logic [3:0]  st;
      logic [15:0] strb;
      logic        ill;
      logic [15:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        run0 = 1'b0;
   logic        run2 = 1'b0;
   logic        halt = 1'b1;
   logic        con = 1'b0;
   logic [4:0]  op = 5'd0;
   logic [3:0]  st0, st2;
   logic [15:0] strb0, strb2;
   logic        ill0, ill2;
   logic [1:0]  cnt0;
   logic [15:0] cnt2;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   branch_sequencer #(.MEM_WAIT(0), .CNT_W(2)) u0 (
      .clk(clk), .clr(clr), .run(run0), .halt(halt),
`ifdef BRANCH_SEQ_STEP_EN
      .step(1'b1),
`endif
      .ir_op(op), .con_ff(con),
      .PCout(strb0[15]), .MARIn(strb0[14]), .IncPC(strb0[13]), .ZIn(strb0[12]),
      .Zlowout(strb0[11]), .PCIn(strb0[10]), .read(strb0[9]), .MDRIn(strb0[8]),
      .MDRout(strb0[7]), .IRIn(strb0[6]), .Gra(strb0[5]), .Rout(strb0[4]),
      .CONIn(strb0[3]), .YIn(strb0[2]), .Cout(strb0[1]), .add(strb0[0]),
      .present_state(st0), .illegal(ill0), .instr_count(cnt0)
   );

   branch_sequencer #(.MEM_WAIT(2)) u2 (
      .clk(clk), .clr(clr), .run(run2), .halt(halt),
`ifdef BRANCH_SEQ_STEP_EN
      .step(1'b1),
`endif
      .ir_op(op), .con_ff(con),
      .PCout(strb2[15]), .MARIn(strb2[14]), .IncPC(strb2[13]), .ZIn(strb2[12]),
      .Zlowout(strb2[11]), .PCIn(strb2[10]), .read(strb2[9]), .MDRIn(strb2[8]),
      .MDRout(strb2[7]), .IRIn(strb2[6]), .Gra(strb2[5]), .Rout(strb2[4]),
      .CONIn(strb2[3]), .YIn(strb2[2]), .Cout(strb2[1]), .add(strb2[0]),
      .present_state(st2), .illegal(ill2), .instr_count(cnt2)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic put(input bit sel, input bit r, input bit con_v, input logic [4:0] op_v,
                      input logic [3:0] st, input logic [15:0] strb, input bit ill,
                      input int cnt);
      vec_t v;
      v.sel  = sel;
      v.run  = r;
      v.halt = 1'b1;
      v.con  = con_v;
      v.op   = op_v;
      v.st   = st;
      v.strb = strb;
      v.ill  = ill;
      v.cnt  = 16'(cnt);
      tbl.push_back(v);
   endtask

   // Expected step sequence for one instruction started from IDLE with halt=1
   task automatic gen_instr(input bit sel, input int mw, input logic [4:0] op_v,
                            input bit con_v, input int cb, input int md);
      put(sel, 1, con_v, op_v, 4'h0, 16'h0000, 0, cb);
      put(sel, 0, con_v, op_v, 4'h7, 16'hF000, 0, cb);
      put(sel, 0, con_v, op_v, 4'h8, 16'h0F00, 0, cb);
      for (int j = 0; j < mw; j++) put(sel, 0, con_v, op_v, 4'h8, 16'h0300, 0, cb);
      put(sel, 0, con_v, op_v, 4'h9, 16'h00C0, 0, cb);
      if (op_v == BR) begin
         put(sel, 0, con_v, op_v, 4'hA, 16'h0038, 0, cb);
         put(sel, 0, con_v, op_v, 4'hB, 16'h8004, 0, cb);
         put(sel, 0, con_v, op_v, 4'hC, 16'h1003, 0, cb);
         for (int j = 0; j <= mw; j++)
            put(sel, 0, con_v, op_v, 4'hD, con_v ? 16'h0C00 : 16'h0000, 0, cb);
         put(sel, 0, con_v, op_v, 4'h0, 16'h0000, 0, (cb + 1) % md);
      end else begin
         put(sel, 0, con_v, op_v, 4'hA, 16'h0000, 1, cb);
         put(sel, 0, con_v, op_v, 4'h0, 16'h0000, 0, cb);
      end
   endtask

   task automatic apply_tbl(input string name);
      vec_t v, e;
      logic [36:0] got, want;
      for (int i = 0; i < tbl.size(); i++) begin
         v    = tbl[i];
         run0 = (v.sel == 1'b0) ? v.run : 1'b0;
         run2 = (v.sel == 1'b1) ? v.run : 1'b0;
         halt = v.halt;
         con  = v.con;
         op   = v.op;
         sb.push_back(v);
         #1;
         e = sb.pop_front();
         if (e.sel == 1'b0) got = {st0, strb0, ill0, 14'd0, cnt0};
         else               got = {st2, strb2, ill2, cnt2};
         want = {e.st, e.strb, e.ill, e.cnt};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got st=%h strb=%h ill=%b cnt=%0d want st=%h strb=%h ill=%b cnt=%0d",
                     name, i, got[36:33], got[32:17], got[16], got[15:0],
                     e.st, e.strb, e.ill, e.cnt);
         end
         @(posedge clk);
         #1;
      end
      tbl.delete();
   endtask

   initial begin
      #1 clr = 1'b1;
      #1;
      chk("rst_st0", 32'(st0), 32'h0);
      chk("rst_strb0", 32'(strb0), 32'h0);
      chk("rst_ill2", 32'(ill2), 32'h0);
      chk("rst_cnt2", 32'(cnt2), 32'h0);
      @(posedge clk);
      #1 clr = 1'b0;

      gen_instr(0, 0, BR, 1, 0, 4);
      apply_tbl("taken_mw0");
      gen_instr(0, 0, BR, 0, 1, 4);
      apply_tbl("nottaken_mw0");
      gen_instr(0, 0, BAD, 1, 2, 4);
      apply_tbl("illegal_mw0");
      gen_instr(1, 2, BR, 1, 0, 65536);
      apply_tbl("taken_mw2");

      op   = BR;
      con  = 1'b1;
      halt = 1'b1;
      run2 = 1'b1;
      @(posedge clk);
      #1 run2 = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("pre_rst_t5", 32'(st2), 32'hC);
      #2 clr = 1'b1;
      #1;
      chk("async_st", 32'(st2), 32'h0);
      chk("async_strb", 32'(strb2), 32'h0);
      chk("async_ill", 32'(ill2), 32'h0);
      chk("async_cnt2", 32'(cnt2), 32'h0);
      chk("async_cnt0", 32'(cnt0), 32'h0);
      @(posedge clk);
      #1 clr = 1'b0;

      halt = 1'b0;
      run0 = 1'b1;
      @(posedge clk);
      #1 run0 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) halt = 1'b1;
         repeat (7) @(posedge clk);
         #1;
         chk($sformatf("wrap_cnt%0d", k), 32'(cnt0), 32'(k % 4));
         chk($sformatf("wrap_st%0d", k), 32'(st0), (k == 5) ? 32'h0 : 32'h7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
